// File: rtl/seq_divider_if.sv
// seq_divider_if
//   Operand/result bundle for the sequential divider.
//   master : requester side (drives start and operands, observes results)
//   slave  : divider side (observes start and operands, drives results)
//   Signals:
//     start        request pulse/level, sampled by the divider only when idle
//     dividend     unsigned dividend (DIVIDEND_W bits)
//     divisor      unsigned divisor (DIVISOR_W bits)
//     busy         high while quotient bits are being resolved
//     done         one-cycle pulse, result valid
//     quotient     registered quotient (DIVIDEND_W bits)
//     remainder    registered remainder (DIVISOR_W bits)
//     div_by_zero  flags a result produced for a zero divisor
interface seq_divider_if #(
    parameter int DIVIDEND_W = 8,
    parameter int DIVISOR_W  = 4
) ();
    logic                  start;
    logic [DIVIDEND_W-1:0] dividend;
    logic [DIVISOR_W-1:0]  divisor;
    logic                  busy;
    logic                  done;
    logic [DIVIDEND_W-1:0] quotient;
    logic [DIVISOR_W-1:0]  remainder;
    logic                  div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_divider.sv
// seq_divider
//   Sequential restoring divider: one quotient bit per clock. Operands are
//   captured when start is seen in IDLE; after DIVIDEND_W iterations the
//   quotient and remainder are registered and done pulses for one cycle.
//   A zero divisor skips the iterations and returns all-ones / zero with
//   div_by_zero set.
//   Ports:
//     clk  rising-edge clock
//     rst  synchronous, active-high reset (wins over everything)
//     bus  seq_divider_if.slave: start/dividend/divisor in,
//          busy/done/quotient/remainder/div_by_zero out (all registered)
module seq_divider #(
    parameter int DIVIDEND_W = 8,
    parameter int DIVISOR_W  = 4
) (
    input  logic         clk,
    input  logic         rst,
    seq_divider_if.slave bus
);
    localparam int CNT_W = $clog2(DIVIDEND_W + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state_r;
    // Dividend bits shift out of the MSB while quotient bits shift into the
    // LSB, so a single register serves both.
    logic [DIVIDEND_W-1:0] dq_r;
    logic [DIVISOR_W-1:0]  dvs_r;
    logic [DIVISOR_W:0]    prem_r;
    logic [CNT_W-1:0]      count_r;
    logic                  busy_r;
    logic                  done_r;
    logic                  dbz_r;
    logic [DIVIDEND_W-1:0] quotient_r;
    logic [DIVISOR_W-1:0]  remainder_r;

    logic [DIVISOR_W+1:0]  shifted_s;
    logic [DIVISOR_W:0]    trial_s;
    logic                  fits_s;
    logic [DIVISOR_W:0]    prem_next_s;
    logic [DIVIDEND_W-1:0] dq_next_s;
    logic                  last_s;

    // One restoring-division step on the current working registers.
    always_comb begin
        shifted_s = {prem_r, dq_r[DIVIDEND_W-1]};
        fits_s    = (shifted_s >= {2'b00, dvs_r});
        // Only used when fits_s holds; the difference is then below the
        // divisor, so the low DIVISOR_W+1 bits carry the whole result.
        trial_s   = shifted_s[DIVISOR_W:0] - {1'b0, dvs_r};
        if (fits_s) begin
            prem_next_s = trial_s;
            dq_next_s   = {dq_r[DIVIDEND_W-2:0], 1'b1};
        end else begin
            prem_next_s = shifted_s[DIVISOR_W:0];
            dq_next_s   = {dq_r[DIVIDEND_W-2:0], 1'b0};
        end
        last_s = (count_r == CNT_W'(DIVIDEND_W - 1));
    end

    // Control FSM, working registers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            dq_r        <= {DIVIDEND_W{1'b0}};
            dvs_r       <= {DIVISOR_W{1'b0}};
            prem_r      <= {(DIVISOR_W + 1){1'b0}};
            count_r     <= {CNT_W{1'b0}};
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            dbz_r       <= 1'b0;
            quotient_r  <= {DIVIDEND_W{1'b0}};
            remainder_r <= {DIVISOR_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        if (bus.divisor != {DIVISOR_W{1'b0}}) begin
                            dq_r    <= bus.dividend;
                            dvs_r   <= bus.divisor;
                            prem_r  <= {(DIVISOR_W + 1){1'b0}};
                            count_r <= {CNT_W{1'b0}};
                            dbz_r   <= 1'b0;
                            busy_r  <= 1'b1;
                            state_r <= RUN;
                        end else begin
                            // Zero divisor: report immediately, no iterations.
                            quotient_r  <= {DIVIDEND_W{1'b1}};
                            remainder_r <= {DIVISOR_W{1'b0}};
                            dbz_r       <= 1'b1;
                            done_r      <= 1'b1;
                            state_r     <= DONE;
                        end
                    end
                end
                RUN: begin
                    prem_r  <= prem_next_s;
                    dq_r    <= dq_next_s;
                    count_r <= count_r + CNT_W'(1);
                    if (last_s) begin
                        quotient_r  <= dq_next_s;
                        remainder_r <= prem_next_s[DIVISOR_W-1:0];
                        busy_r      <= 1'b0;
                        done_r      <= 1'b1;
                        state_r     <= DONE;
                    end
                end
                DONE: begin
                    done_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.quotient    = quotient_r;
    assign bus.remainder   = remainder_r;
    assign bus.div_by_zero = dbz_r;
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider
//   Self-checking bench for seq_divider: a table of directed vectors, hand
//   sequences for start-during-RUN and reset-abort, and an exhaustive sweep
//   with start held high. Expected results are queued when a request is
//   driven and compared when done pulses.
module tb_seq_divider;
    localparam int DW = 8;
    localparam int VW = 4;

    typedef struct {
        logic [DW-1:0] q;
        logic [VW-1:0] r;
        logic          dbz;
    } exp_t;

    typedef struct {
        logic [DW-1:0] a;
        logic [VW-1:0] b;
        logic [DW-1:0] q;
        logic [VW-1:0] r;
        logic          dbz;
    } vec_t;

    logic clk;
    logic rst;
    int   nvec;
    int   nerr;
    exp_t sb[$];
    vec_t tbl[13];

    seq_divider_if #(.DIVIDEND_W(DW), .DIVISOR_W(VW)) bus ();

    seq_divider #(.DIVIDEND_W(DW), .DIVISOR_W(VW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t ref_div(input logic [DW-1:0] a, input logic [VW-1:0] b);
        exp_t e;
        if (b == 4'd0) begin
            e.q   = 8'hFF;
            e.r   = 4'd0;
            e.dbz = 1'b1;
        end else begin
            e.q   = a / {4'd0, b};
            e.r   = VW'(a % {4'd0, b});
            e.dbz = 1'b0;
        end
        return e;
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_zero(input string name);
        cmp({name, ".busy"},  {31'd0, bus.busy},        32'd0);
        cmp({name, ".done"},  {31'd0, bus.done},        32'd0);
        cmp({name, ".q"},     {24'd0, bus.quotient},    32'd0);
        cmp({name, ".r"},     {28'd0, bus.remainder},   32'd0);
        cmp({name, ".dbz"},   {31'd0, bus.div_by_zero}, 32'd0);
    endtask

    task automatic check_result(input string name);
        exp_t e;
        if (sb.size() == 0) begin
            nvec++;
            nerr++;
            $display("FAIL %s: done pulse with no request outstanding", name);
        end else begin
            e = sb.pop_front();
            cmp({name, ".q"},   {24'd0, bus.quotient},    {24'd0, e.q});
            cmp({name, ".r"},   {28'd0, bus.remainder},   {28'd0, e.r});
            cmp({name, ".dbz"}, {31'd0, bus.div_by_zero}, {31'd0, e.dbz});
        end
    endtask

    // Call at the negedge where start was just driven (or the last done cycle).
    task automatic wait_done(input int exp_lat, input int exp_busy, input bit hold,
                             input int scr, input string name);
        int n      = 0;
        int busy_n = 0;
        bit seen   = 1'b0;
        while (!seen && n < exp_lat + 4) begin
            @(negedge clk);
            n++;
            if (n == 1 && !hold) bus.start = 1'b0;
            if (n == scr) begin
                bus.dividend = DW'($urandom);
                bus.divisor  = VW'($urandom);
            end
            if (bus.busy) busy_n++;
            if (bus.done) seen = 1'b1;
        end
        if (!seen) begin
            nvec++;
            nerr++;
            $display("FAIL %s: no done within %0d cycles", name, exp_lat + 4);
            if (sb.size() > 0) void'(sb.pop_front());
        end else begin
            check_result(name);
            cmp({name, ".latency"}, n, exp_lat);
            cmp({name, ".busy_cycles"}, busy_n, exp_busy);
        end
    endtask

    task automatic issue(input logic [DW-1:0] a, input logic [VW-1:0] b, input bit push);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        if (push) sb.push_back(ref_div(a, b));
    endtask

    initial begin
        int   pulses;
        exp_t e;
        nvec = 0;
        nerr = 0;
        tbl[0]  = '{8'd110, 4'd11, 8'd10,  4'd0, 1'b0};
        tbl[1]  = '{8'd200, 4'd7,  8'd28,  4'd4, 1'b0};
        tbl[2]  = '{8'd255, 4'd1,  8'd255, 4'd0, 1'b0};
        tbl[3]  = '{8'd5,   4'd9,  8'd0,   4'd5, 1'b0};
        tbl[4]  = '{8'd255, 4'd15, 8'd17,  4'd0, 1'b0};
        tbl[5]  = '{8'd42,  4'd0,  8'hFF,  4'd0, 1'b1};
        tbl[6]  = '{8'd12,  4'd4,  8'd3,   4'd0, 1'b0};
        tbl[7]  = '{8'd77,  4'd6,  8'd12,  4'd5, 1'b0};
        tbl[8]  = '{8'd0,   4'd5,  8'd0,   4'd0, 1'b0};
        tbl[9]  = '{8'd1,   4'd15, 8'd0,   4'd1, 1'b0};
        tbl[10] = '{8'd15,  4'd15, 8'd1,   4'd0, 1'b0};
        tbl[11] = '{8'd128, 4'd3,  8'd42,  4'd2, 1'b0};
        tbl[12] = '{8'd0,   4'd0,  8'hFF,  4'd0, 1'b1};

        bus.start    = 1'b0;
        bus.dividend = 8'd0;
        bus.divisor  = 4'd0;
        rst          = 1'b1;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // Directed table, each request issued from IDLE.
        for (int i = 0; i < 13; i++) begin
            bus.start    = 1'b1;
            bus.dividend = tbl[i].a;
            bus.divisor  = tbl[i].b;
            e.q   = tbl[i].q;
            e.r   = tbl[i].r;
            e.dbz = tbl[i].dbz;
            sb.push_back(e);
            if (tbl[i].b == 4'd0)
                wait_done(1, 0, 1'b0, 0, $sformatf("vec%0d", i));
            else
                wait_done(9, 8, 1'b0, 1, $sformatf("vec%0d", i));
            @(negedge clk);
            cmp($sformatf("vec%0d.done_pulse", i), {31'd0, bus.done}, 32'd0);
        end

        // Second start during RUN must be ignored.
        issue(8'd100, 4'd3, 1'b1);
        pulses = 0;
        for (int n = 1; n <= 14; n++) begin
            @(negedge clk);
            if (n == 1) bus.start = 1'b0;
            if (n == 3) issue(8'd9, 4'd9, 1'b0);
            if (n == 4) bus.start = 1'b0;
            if (bus.done) begin
                pulses++;
                check_result("run_restart");
            end
        end
        cmp("run_restart.pulses", pulses, 1);
        issue(8'd9, 4'd9, 1'b1);
        wait_done(9, 8, 1'b0, 0, "nine_by_nine");
        @(negedge clk);

        // Reset in the 4th RUN cycle aborts the operation.
        issue(8'd200, 4'd7, 1'b0);
        for (int n = 1; n <= 4; n++) begin
            @(negedge clk);
            if (n == 1) bus.start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_zero("abort");
        pulses = 0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (bus.done) pulses++;
        end
        cmp("abort.pulses", pulses, 0);
        issue(8'd77, 4'd6, 1'b1);
        wait_done(9, 8, 1'b0, 0, "after_abort");
        @(negedge clk);

        // Exhaustive sweep with start held high: one accept per IDLE cycle.
        for (int i = 0; i < 256 * 15; i++) begin
            issue(DW'(i / 15), VW'(i % 15 + 1), 1'b1);
            if (i == 0)
                wait_done(9, 8, 1'b1, 1, "sweep");
            else
                wait_done(10, 8, 1'b1, 2, $sformatf("sweep%0d", i));
        end
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        cmp("final.queue_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
